quad_decoder: RTL and testbench

- Quadrature decoder front end for the up/down counting path.
- Takes two-phase encoder inputs (a_in, b_in) and synchronizes them.
- Detects step direction and maintains a wrap-around position count.
- Produces the direction bit using the counter-side convention: m=0 counts up, m=1 counts down.

---
 rtl/qdec_pkg.sv | 33 +++
 rtl/qdec_sync.sv | 56 +++++
 rtl/quad_decoder.sv | 132 +++++++++++++
 tb/tb_quad_decoder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/qdec_pkg.sv
// Shared types and step decoding for the quadrature decoder.
// QDEC_FILTER_EN selects the input stability filter build.
package qdec_pkg;

    typedef enum logic {INIT, RUN} state_t;

    typedef enum logic [1:0] {NONE, UP, DN, ILLEGAL} move_t;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

`ifdef QDEC_FILTER_EN
    localparam bit FILT_ON = 1'b1;
`else
    localparam bit FILT_ON = 1'b0;
`endif

    // Up sequence is the Gray walk 00->01->11->10->00; its successor is {prev[0], ~prev[1]}.
    function automatic move_t qdec_move(input logic [1:0] prev, input logic [1:0] cur);
        move_t mv;
        if (prev == cur) begin
            mv = NONE;
        end else if ((prev ^ cur) == 2'b11) begin
            mv = ILLEGAL;
        end else if (cur == {prev[0], ~prev[1]}) begin
            mv = UP;
        end else begin
            mv = DN;
        end
        return mv;
    endfunction

endpackage

// File: rtl/qdec_sync.sv
// One-bit input synchronizer with an optional stability filter.
// QDEC_FILTER_EN adds the FILT_LEN-cycle filter after the synchronizer.
module qdec_sync
    import qdec_pkg::*;
#(
    parameter int SYNC_STAGES = 2
`ifdef QDEC_FILTER_EN
    , parameter int FILT_LEN = 3
`endif
) (
    input  logic clk,
    input  logic clr,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_synced;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        end
    end

    assign w_synced = r_sync[SYNC_STAGES-1];

`ifdef QDEC_FILTER_EN
    localparam int CW = $clog2(FILT_LEN + 1);

    logic [CW-1:0] r_cnt;
    logic          r_filt;

    // Adopt the new level on the FILT_LEN-th consecutive cycle it differs from the held one.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_cnt  <= '0;
            r_filt <= 1'b0;
        end else if (w_synced == r_filt) begin
            r_cnt <= '0;
        end else if (r_cnt == CW'(FILT_LEN - 1)) begin
            r_filt <= w_synced;
            r_cnt  <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_q = r_filt;
`else
    assign o_q = w_synced;
`endif

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronized A/B phases, INIT/RUN FSM, wrap-around count, sticky err.
// QDEC_FILTER_EN enables the input stability filter and lengthens INIT accordingly.
module quad_decoder
    import qdec_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             err_clr,
    output logic [WIDTH-1:0] q,
    output logic             m,
    output logic             step,
    output logic             err
);

    localparam int INIT_LEN = SYNC_STAGES + 1 + (FILT_ON ? FILT_LEN : 0);
    localparam int ICW      = $clog2(INIT_LEN);

    logic             w_a;
    logic             w_b;
    logic [1:0]       w_s;
    move_t            w_move;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ICW-1:0]   r_init_cnt;
    logic [ICW-1:0]   w_init_cnt_nxt;
    logic [1:0]       r_prev;
    logic [WIDTH-1:0] r_q;
    logic             r_m;
    logic             r_step;
    logic             r_err;

    qdec_sync #(
        .SYNC_STAGES(SYNC_STAGES)
`ifdef QDEC_FILTER_EN
        , .FILT_LEN(FILT_LEN)
`endif
    ) u_sync_a (
        .clk (clk),
        .clr (clr),
        .i_d (a_in),
        .o_q (w_a)
    );

    qdec_sync #(
        .SYNC_STAGES(SYNC_STAGES)
`ifdef QDEC_FILTER_EN
        , .FILT_LEN(FILT_LEN)
`endif
    ) u_sync_b (
        .clk (clk),
        .clr (clr),
        .i_d (b_in),
        .o_q (w_b)
    );

    assign w_s    = {w_a, w_b};
    assign w_move = qdec_move(r_prev, w_s);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state    <= INIT;
            r_init_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_cnt <= w_init_cnt_nxt;
        end
    end

    // INIT lets the synchronizer pipeline settle so levels present at reset release are not counted.
    always_comb begin
        w_state_nxt    = r_state;
        w_init_cnt_nxt = r_init_cnt;
        case (r_state)
            INIT: begin
                if (r_init_cnt == ICW'(INIT_LEN - 1)) begin
                    w_state_nxt = RUN;
                end else begin
                    w_init_cnt_nxt = r_init_cnt + 1'b1;
                end
            end
            RUN:     w_state_nxt = RUN;
            default: w_state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_prev <= 2'b00;
            r_q    <= '0;
            r_m    <= DIR_UP;
            r_step <= 1'b0;
        end else begin
            r_prev <= w_s;
            r_step <= 1'b0;
            if (r_state == RUN) begin
                if (w_move == UP) begin
                    r_q    <= r_q + 1'b1;
                    r_m    <= DIR_UP;
                    r_step <= 1'b1;
                end else if (w_move == DN) begin
                    r_q    <= r_q - 1'b1;
                    r_m    <= DIR_DN;
                    r_step <= 1'b1;
                end
            end
        end
    end

    // A new illegal transition outranks a simultaneous clear.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_err <= 1'b0;
        end else if (r_state == RUN && w_move == ILLEGAL) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign q    = r_q;
    assign m    = r_m;
    assign step = r_step;
    assign err  = r_err;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder; follows the filtered timing when QDEC_FILTER_EN is defined.
module tb_quad_decoder;

    localparam int WIDTH       = 8;
    localparam int SYNC_STAGES = 2;
    localparam int FILT_LEN    = 3;
`ifdef QDEC_FILTER_EN
    localparam int LAT      = SYNC_STAGES + FILT_LEN;
    localparam int INIT_LEN = SYNC_STAGES + FILT_LEN + 1;
`else
    localparam int LAT      = SYNC_STAGES;
    localparam int INIT_LEN = SYNC_STAGES + 1;
`endif
    localparam int HOLD = LAT + 3;

    logic             clk = 1'b0;
    logic             clr;
    logic             a_in;
    logic             b_in;
    logic             err_clr;
    logic [WIDTH-1:0] q;
    logic             m;
    logic             step;
    logic             err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    quad_decoder #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_LEN   (FILT_LEN)
    ) dut (
        .clk     (clk),
        .clr     (clr),
        .a_in    (a_in),
        .b_in    (b_in),
        .err_clr (err_clr),
        .q       (q),
        .m       (m),
        .step    (step),
        .err     (err)
    );

    // Driver: reset with given input levels, release, and wait past INIT.
    task automatic do_reset(input logic [1:0] ab);
        @(negedge clk);
        clr     = 1'b1;
        a_in    = ab[1];
        b_in    = ab[0];
        err_clr = 1'b0;
        repeat (3) @(negedge clk);
        clr = 1'b0;
        repeat (INIT_LEN + LAT + 2) @(negedge clk);
    endtask

    // Driver/monitor: apply {a,b} at a falling edge, watch step for a number of rising edges.
    task automatic apply_ab(input logic [1:0] ab, input int cycles, output int pulses, output int first_at);
        pulses   = 0;
        first_at = -1;
        @(negedge clk);
        a_in = ab[1];
        b_in = ab[0];
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (step === 1'b1) begin
                pulses++;
                if (first_at < 0) first_at = i;
            end
        end
    endtask

    task automatic test_reset();
        int p;
        clr = 1'b1; a_in = 1'b1; b_in = 1'b1; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (q !== 8'h00)  begin bad++; $display("FAIL reset_q: got %0h expected 0", q); end
        total++; if (m !== 1'b0)   begin bad++; $display("FAIL reset_m: got %0b expected 0", m); end
        total++; if (step !== 1'b0) begin bad++; $display("FAIL reset_step: got %0b expected 0", step); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %0b expected 0", err); end
        @(negedge clk);
        clr = 1'b0;
        p = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (step === 1'b1) p++;
        end
        total++; if (p !== 0)      begin bad++; $display("FAIL init_absorb_pulses: got %0d expected 0", p); end
        total++; if (q !== 8'h00)  begin bad++; $display("FAIL init_absorb_q: got %0h expected 0", q); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL init_absorb_err: got %0b expected 0", err); end
    endtask

    task automatic test_up_steps();
        logic [1:0] seq [4];
        int p, f, sum;
        seq[0] = 2'b01; seq[1] = 2'b11; seq[2] = 2'b10; seq[3] = 2'b00;
        do_reset(2'b00);
        sum = 0;
        for (int k = 0; k < 4; k++) begin
            apply_ab(seq[k], HOLD, p, f);
            sum += p;
            total++; if (f !== LAT) begin bad++; $display("FAIL up_latency[%0d]: got %0d expected %0d", k, f, LAT); end
            total++; if (q !== 8'(k + 1)) begin bad++; $display("FAIL up_q[%0d]: got %0h expected %0h", k, q, k + 1); end
        end
        total++; if (sum !== 4)  begin bad++; $display("FAIL up_pulses: got %0d expected 4", sum); end
        total++; if (m !== 1'b0) begin bad++; $display("FAIL up_m: got %0b expected 0", m); end
    endtask

    task automatic test_down_wrap();
        int p, f;
        do_reset(2'b00);
        apply_ab(2'b10, HOLD, p, f);
        total++; if (p !== 1)     begin bad++; $display("FAIL dn_pulses: got %0d expected 1", p); end
        total++; if (q !== 8'hFF) begin bad++; $display("FAIL dn_wrap_q: got %0h expected ff", q); end
        total++; if (m !== 1'b1)  begin bad++; $display("FAIL dn_m: got %0b expected 1", m); end
        apply_ab(2'b00, HOLD, p, f);
        total++; if (q !== 8'h00) begin bad++; $display("FAIL up_wrap_q: got %0h expected 0", q); end
        total++; if (m !== 1'b0)  begin bad++; $display("FAIL up_wrap_m: got %0b expected 0", m); end
    endtask

    task automatic test_err();
        int p, f;
        do_reset(2'b00);
        apply_ab(2'b11, HOLD, p, f);
        total++; if (p !== 0)     begin bad++; $display("FAIL illegal_pulses: got %0d expected 0", p); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL illegal_err: got %0b expected 1", err); end
        total++; if (q !== 8'h00) begin bad++; $display("FAIL illegal_q: got %0h expected 0", q); end
        apply_ab(2'b01, HOLD, p, f);
        total++; if (q !== 8'hFF) begin bad++; $display("FAIL err_dn_q: got %0h expected ff", q); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %0b expected 1", err); end
        // 01->10 is illegal; err_clr is high exactly on the edge that detects it.
        @(negedge clk);
        a_in = 1'b1; b_in = 1'b0;
        repeat (LAT) @(posedge clk);
        @(negedge clk);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        total++; if (err !== 1'b1)  begin bad++; $display("FAIL set_wins_err: got %0b expected 1", err); end
        total++; if (step !== 1'b0) begin bad++; $display("FAIL set_wins_step: got %0b expected 0", step); end
        total++; if (q !== 8'hFF)   begin bad++; $display("FAIL set_wins_q: got %0h expected ff", q); end
        total++; if (m !== 1'b1)    begin bad++; $display("FAIL set_wins_m: got %0b expected 1", m); end
        @(negedge clk);
        err_clr = 1'b0;
        repeat (3) @(negedge clk);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        total++; if (err !== 1'b0) begin bad++; $display("FAIL err_clr: got %0b expected 0", err); end
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic test_clr_async();
        logic [1:0] seq [6];
        int p, f;
        seq[0] = 2'b01; seq[1] = 2'b11; seq[2] = 2'b10;
        seq[3] = 2'b00; seq[4] = 2'b01; seq[5] = 2'b11;
        do_reset(2'b00);
        for (int k = 0; k < 6; k++) apply_ab(seq[k], HOLD, p, f);
        apply_ab(2'b01, HOLD, p, f);
        apply_ab(2'b10, HOLD, p, f);
        total++; if (q !== 8'h05) begin bad++; $display("FAIL pre_clr_q: got %0h expected 5", q); end
        total++; if (m !== 1'b1)  begin bad++; $display("FAIL pre_clr_m: got %0b expected 1", m); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL pre_clr_err: got %0b expected 1", err); end
        @(negedge clk);
        #2;
        clr = 1'b1;
        #1;
        total++; if (q !== 8'h00) begin bad++; $display("FAIL async_clr_q: got %0h expected 0", q); end
        total++; if (m !== 1'b0)  begin bad++; $display("FAIL async_clr_m: got %0b expected 0", m); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL async_clr_err: got %0b expected 0", err); end
        #1;
        clr = 1'b0;
        p = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (step === 1'b1) p++;
        end
        total++; if (p !== 0)     begin bad++; $display("FAIL reinit_pulses: got %0d expected 0", p); end
        total++; if (q !== 8'h00) begin bad++; $display("FAIL reinit_q: got %0h expected 0", q); end
        apply_ab(2'b00, HOLD, p, f);
        total++; if (q !== 8'h01) begin bad++; $display("FAIL reinit_step_q: got %0h expected 1", q); end
    endtask

`ifndef QDEC_FILTER_EN
    task automatic test_back_to_back();
        logic [1:0] seq [4];
        logic exp_step;
        seq[0] = 2'b01; seq[1] = 2'b11; seq[2] = 2'b10; seq[3] = 2'b00;
        do_reset(2'b00);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i < 4) begin
                a_in = seq[i][1];
                b_in = seq[i][0];
            end
            @(posedge clk);
            #1;
            exp_step = (i >= LAT) && (i < LAT + 4);
            total++; if (step !== exp_step) begin bad++; $display("FAIL b2b_step[%0d]: got %0b expected %0b", i, step, exp_step); end
        end
        total++; if (q !== 8'h04) begin bad++; $display("FAIL b2b_q: got %0h expected 4", q); end
    endtask
`else
    task automatic test_filter();
        int p, f;
        do_reset(2'b00);
        @(negedge clk);
        a_in = 1'b1;
        repeat (2) @(negedge clk);
        a_in = 1'b0;
        p = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (step === 1'b1) p++;
        end
        total++; if (p !== 0)     begin bad++; $display("FAIL glitch_pulses: got %0d expected 0", p); end
        total++; if (q !== 8'h00) begin bad++; $display("FAIL glitch_q: got %0h expected 0", q); end
        apply_ab(2'b10, HOLD, p, f);
        total++; if (p !== 1)     begin bad++; $display("FAIL filt_pulses: got %0d expected 1", p); end
        total++; if (f !== SYNC_STAGES + FILT_LEN) begin bad++; $display("FAIL filt_latency: got %0d expected %0d", f, SYNC_STAGES + FILT_LEN); end
        total++; if (q !== 8'hFF) begin bad++; $display("FAIL filt_q: got %0h expected ff", q); end
    endtask
`endif

    initial begin
        test_reset();
        test_up_steps();
        test_down_wrap();
        test_err();
        test_clr_async();
`ifndef QDEC_FILTER_EN
        test_back_to_back();
`else
        test_filter();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
